median3x3_stream: RTL

Streaming, parametrised 3x3 neighbourhood filter for raster-order greyscale frames. It replaces nine parallel BRAM window reads with two internal line buffers, so it needs one input pixel per accepted cycle and emits exactly one output pixel per input pixel. It adds runtime selection of median/min/max/bypass, configurable border handling, and an automatic end-of-frame flush. It sits between the BMP header parser (pixel stream after `header_done`) and the output writer.

---
 rtl/median3x3_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/median3x3_stream.sv
// median3x3_stream: raster-order 3x3 median/min/max/bypass filter using line buffers, with border handling and an end-of-frame flush.
module median3x3_stream #(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 100,
    parameter int IMG_H     = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           filter_sel,
    input  logic                 border_mode,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(N + 1);
    localparam int LB = 2 * IMG_W + 2;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_FILL = CW'(IMG_W + 1);
    localparam logic [CW-1:0] C_W    = CW'(IMG_W);
    localparam logic [CW-1:0] C_WM1  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_HM1  = CW'(IMG_H - 1);

    typedef logic [BIT_WIDTH-1:0] pix_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic pix_t mn(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t mx(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t md3(input pix_t a, input pix_t b, input pix_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, row_q, row_d, col_q, col_d;
    logic [1:0]    sel_q, sel_d;
    logic          bmode_q, bmode_d, busy_q, busy_d;
    logic          adv, ctr_v, border, last;
    pix_t          adv_pix;
    pix_t          lb_q [LB];
    pix_t          win [9];

    logic          v1_q, last1_q, dir1_q;
    logic [1:0]    op1_q;
    pix_t          dv1_q;
    pix_t          w1_q [9];

    logic          v2_q, last2_q, dir2_q;
    logic [1:0]    op2_q;
    pix_t          dv2_q;
    pix_t          lo2_q [3];
    pix_t          md2_q [3];
    pix_t          hi2_q [3];

    logic          out_valid_q, frame_done_q;
    pix_t          out_data_q, med, res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        sel_d   = sel_q;
        bmode_d = bmode_q;
        busy_d  = busy_q && !frame_done_q;
        adv     = 1'b0;
        adv_pix = in_data;
        if (state_q == IDLE) begin
            if (start && !busy_q) begin
                state_d = RUN;
                cnt_d   = '0;
                row_d   = '0;
                col_d   = '0;
                sel_d   = filter_sel;
                bmode_d = border_mode;
                busy_d  = 1'b1;
            end
        end else if (state_q == RUN) begin
            adv = in_valid;
            if (in_valid) begin
                cnt_d   = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == C_LAST) ? FLUSH : RUN;
            end
        end else begin
            adv     = 1'b1;
            adv_pix = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == C_W) ? IDLE : FLUSH;
        end
        // A window is complete once IMG_W+1 pixels have been shifted in; every flush tick completes one.
        ctr_v = adv && ((state_q == FLUSH) || (cnt_q >= C_FILL));
        if (ctr_v) begin
            col_d = (col_q == C_WM1) ? '0 : col_q + 1'b1;
            row_d = (col_q == C_WM1) ? row_q + 1'b1 : row_q;
        end
    end

    assign win[0] = lb_q[2*IMG_W+1];
    assign win[1] = lb_q[2*IMG_W];
    assign win[2] = lb_q[2*IMG_W-1];
    assign win[3] = lb_q[IMG_W+1];
    assign win[4] = lb_q[IMG_W];
    assign win[5] = lb_q[IMG_W-1];
    assign win[6] = lb_q[1];
    assign win[7] = lb_q[0];
    assign win[8] = adv_pix;

    assign border = (row_q == '0) || (row_q == C_HM1) || (col_q == '0) || (col_q == C_WM1);
    assign last   = (row_q == C_HM1) && (col_q == C_WM1);

    // Median of nine from row-sorted triples: max of lows, median of mids, min of highs.
    assign med = md3(mx(mx(lo2_q[0], lo2_q[1]), lo2_q[2]),
                     md3(md2_q[0], md2_q[1], md2_q[2]),
                     mn(mn(hi2_q[0], hi2_q[1]), hi2_q[2]));
    assign res = dir2_q ? dv2_q :
                 (op2_q == 2'd0) ? med :
                 (op2_q == 2'd1) ? mn(mn(lo2_q[0], lo2_q[1]), lo2_q[2]) :
                                   mx(mx(hi2_q[0], hi2_q[1]), hi2_q[2]);

    always_ff @(posedge clk) begin
        if (adv) begin
            lb_q[0] <= adv_pix;
            for (int i = 1; i < LB; i++) lb_q[i] <= lb_q[i-1];
        end
        w1_q    <= win;
        last1_q <= last;
        op1_q   <= sel_q;
        dir1_q  <= border || (sel_q == 2'd3);
        dv1_q   <= (border && !bmode_q) ? '0 : win[4];
        for (int i = 0; i < 3; i++) begin
            lo2_q[i] <= mn(mn(w1_q[3*i], w1_q[3*i+1]), w1_q[3*i+2]);
            md2_q[i] <= md3(w1_q[3*i], w1_q[3*i+1], w1_q[3*i+2]);
            hi2_q[i] <= mx(mx(w1_q[3*i], w1_q[3*i+1]), w1_q[3*i+2]);
        end
        last2_q <= last1_q;
        op2_q   <= op1_q;
        dir2_q  <= dir1_q;
        dv2_q   <= dv1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            sel_q        <= '0;
            bmode_q      <= 1'b0;
            busy_q       <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            sel_q        <= sel_d;
            bmode_q      <= bmode_d;
            busy_q       <= busy_d;
            v1_q         <= ctr_v;
            v2_q         <= v1_q;
            out_valid_q  <= v2_q;
            frame_done_q <= v2_q && last2_q;
            out_data_q   <= v2_q ? res : '0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
endmodule
